// File: rtl/vga_cmd_sequencer.sv
// vga_cmd_sequencer: decodes an SPI byte stream into configuration commits
// and character-cell writes. Config changes are staged in a shadow register
// and applied at vertical blanking; character writes wait for active==0.
module vga_cmd_sequencer #(
  parameter logic [31:0] CFG_RESET  = 32'h80FC0000,
  parameter int          TIMEOUT    = 1024,
  parameter int          CHAR_CELLS = 1200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        vblank_start,
  input  logic        active,
  output logic [31:0] config_out,
  output logic        char_wr,
  output logic [10:0] char_addr,
  output logic [5:0]  char_data,
  output logic        busy,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OP_CFG    = 8'hA0;
  localparam logic [7:0] OP_CHAR   = 8'hB0;
  localparam logic [7:0] OP_COMMIT = 8'hC0;
  localparam logic [7:0] OP_CLRERR = 8'hE0;

  typedef enum logic [1:0] {IDLE, CFG_BYTES, CHAR_BYTES, WAIT_BLANK} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_bcnt, w_bcnt_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic [23:0]   r_asm, w_asm_nxt;

  logic [31:0]   r_cfg, r_shadow;
  logic          r_pend;
  logic          r_err;
  logic [10:0]   r_wr_addr, r_last_addr;
  logic [5:0]    r_wr_data, r_last_data;

  logic w_idle_op, w_cfg_done, w_char_done, w_addr_ok, w_timeout, w_wr;
  logic w_bad_op, w_err_set, w_err_clr;

  // command decode and error sources
  always_comb begin
    w_idle_op   = (r_state == IDLE) && rx_valid;
    w_cfg_done  = (r_state == CFG_BYTES)  && rx_valid && (r_bcnt == 2'd3);
    w_char_done = (r_state == CHAR_BYTES) && rx_valid && (r_bcnt == 2'd2);
    // first two char bytes sit in r_asm[15:0]; bits 10:0 are the cell index
    w_addr_ok   = (32'(r_asm[10:0]) < CHAR_CELLS);
    // r_tmo counts idle cycles; this cycle is the TIMEOUT-th without a byte
    w_timeout   = ((r_state == CFG_BYTES) || (r_state == CHAR_BYTES)) &&
                  !rx_valid && (r_tmo == TW'(TIMEOUT - 1));
    w_wr        = (r_state == WAIT_BLANK) && !active;
    w_bad_op    = w_idle_op && (rx_data != OP_CFG) && (rx_data != OP_CHAR) &&
                  (rx_data != OP_COMMIT) && (rx_data != OP_CLRERR);
    w_err_clr   = w_idle_op && (rx_data == OP_CLRERR);
    w_err_set   = w_bad_op || (w_char_done && !w_addr_ok) || w_timeout ||
                  ((r_state == WAIT_BLANK) && rx_valid);
  end

  // next-state: byte collection, inter-byte timeout, wait for blanking
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_tmo_nxt   = r_tmo;
    w_asm_nxt   = r_asm;
    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_data == OP_CFG || rx_data == OP_CHAR)) begin
          w_state_nxt = (rx_data == OP_CFG) ? CFG_BYTES : CHAR_BYTES;
          w_bcnt_nxt  = 2'd0;
          w_tmo_nxt   = '0;
        end
      end
      CFG_BYTES, CHAR_BYTES: begin
        if (rx_valid) begin
          w_asm_nxt  = {r_asm[15:0], rx_data};
          w_bcnt_nxt = r_bcnt + 2'd1;
          w_tmo_nxt  = '0;
          if (w_cfg_done)
            w_state_nxt = IDLE;
          else if (w_char_done)
            w_state_nxt = w_addr_ok ? WAIT_BLANK : IDLE;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      WAIT_BLANK: begin
        if (!active) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state and collection registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_tmo   <= '0;
      r_asm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_asm   <= w_asm_nxt;
    end
  end

  // shadow/commit path: C0 applies now, otherwise vblank applies a commit
  // armed in an earlier cycle; a CFG finishing this cycle re-arms afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg    <= CFG_RESET;
      r_shadow <= CFG_RESET;
      r_pend   <= 1'b0;
    end else begin
      if (w_idle_op && rx_data == OP_COMMIT) begin
        r_cfg  <= r_shadow;
        r_pend <= 1'b0;
      end else if (vblank_start && r_pend) begin
        r_cfg  <= r_shadow;
        r_pend <= 1'b0;
      end
      if (w_cfg_done) begin
        r_shadow <= {r_asm, rx_data};
        r_pend   <= 1'b1;
      end
    end
  end

  // sticky error, clear wins over a simultaneous set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_err_clr) r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  // pending write latch and last-written hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else begin
      if (w_char_done && w_addr_ok) begin
        r_wr_addr <= r_asm[10:0];
        r_wr_data <= rx_data[5:0];
      end
      if (w_wr) begin
        r_last_addr <= r_wr_addr;
        r_last_data <= r_wr_data;
      end
    end
  end

  // write strobe is combinational so a write requested during blanking
  // lands on the very next cycle; address/data hold between writes
  always_comb begin
    char_wr    = w_wr;
    char_addr  = w_wr ? r_wr_addr : r_last_addr;
    char_data  = w_wr ? r_wr_data : r_last_data;
    config_out = r_cfg;
    busy       = (r_state != IDLE);
    err        = r_err;
  end

endmodule

// File: tb/tb_vga_cmd_sequencer.sv
// Bench for vga_cmd_sequencer: directed table, corner sequences, and random
// byte traffic compared every cycle against a command-level reference model.
module tb_vga_cmd_sequencer;

  localparam int TMO   = 32;
  localparam int CELLS = 1200;
  localparam logic [31:0] CFG_RST = 32'h80FC0000;

  logic        clk, rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid, vblank_start, active;
  logic [31:0] config_out;
  logic        char_wr;
  logic [10:0] char_addr;
  logic [5:0]  char_data;
  logic        busy, err;

  vga_cmd_sequencer #(.CFG_RESET(CFG_RST), .TIMEOUT(TMO), .CHAR_CELLS(CELLS)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .vblank_start(vblank_start), .active(active), .config_out(config_out),
    .char_wr(char_wr), .char_addr(char_addr), .char_data(char_data),
    .busy(busy), .err(err));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model (command level) ----------------
  logic [31:0] m_cfg, m_shadow;
  bit          m_pend, m_err, m_wait;
  logic [7:0]  cmd[$];
  int          m_gap;
  logic [10:0] m_waddr, m_laddr;
  logic [5:0]  m_wdata, m_ldata;

  task automatic model_reset();
    m_cfg = CFG_RST; m_shadow = CFG_RST; m_pend = 0; m_err = 0; m_wait = 0;
    cmd.delete(); m_gap = 0;
    m_waddr = 0; m_laddr = 0; m_wdata = 0; m_ldata = 0;
  endtask

  task automatic model_check();
    logic        e_wr;
    logic [10:0] e_addr;
    logic [5:0]  e_data;
    logic        e_busy;
    e_wr   = m_wait && !active;
    e_addr = e_wr ? m_waddr : m_laddr;
    e_data = e_wr ? m_wdata : m_ldata;
    e_busy = (cmd.size() != 0) || m_wait;
    n_vec++;
    if (config_out !== m_cfg || char_wr !== e_wr || char_addr !== e_addr ||
        char_data !== e_data || busy !== e_busy || err !== m_err) begin
      n_bad++;
      $display("FAIL model @%0t: got cfg=%h wr=%b addr=%0d data=%h busy=%b err=%b, want cfg=%h wr=%b addr=%0d data=%h busy=%b err=%b",
               $time, config_out, char_wr, char_addr, char_data, busy, err,
               m_cfg, e_wr, e_addr, e_data, e_busy, m_err);
    end
  endtask

  task automatic model_update(input logic v, input logic [7:0] d, input logic vb, input logic a);
    int addr;
    if (vb && m_pend) begin m_cfg = m_shadow; m_pend = 0; end
    if (m_wait) begin
      if (!a) begin m_laddr = m_waddr; m_ldata = m_wdata; m_wait = 0; end
      if (v) m_err = 1;
    end else if (cmd.size() == 0) begin
      if (v) begin
        case (d)
          8'hA0, 8'hB0: begin cmd.push_back(d); m_gap = 0; end
          8'hC0: begin m_cfg = m_shadow; m_pend = 0; end
          8'hE0: m_err = 0;
          default: m_err = 1;
        endcase
      end
    end else if (v) begin
      cmd.push_back(d);
      m_gap = 0;
      if (cmd[0] == 8'hA0 && cmd.size() == 5) begin
        m_shadow = {cmd[1], cmd[2], cmd[3], cmd[4]};
        m_pend = 1;
        cmd.delete();
      end else if (cmd[0] == 8'hB0 && cmd.size() == 4) begin
        addr = (int'(cmd[1]) % 8) * 256 + int'(cmd[2]);
        if (addr >= CELLS) m_err = 1;
        else begin
          m_wait  = 1;
          m_waddr = 11'(addr);
          m_wdata = 6'(cmd[3] & 8'h3F);
        end
        cmd.delete();
      end
    end else begin
      m_gap++;
      if (m_gap == TMO) begin m_err = 1; cmd.delete(); end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic vb, input logic a);
    rx_valid = v; rx_data = d; vblank_start = vb; active = a;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_update(rx_valid, rx_data, vblank_start, active);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic vb, input logic a);
    drive(v, d, vb, a); sample(); advance();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v; logic [7:0] d; logic vb; logic a;
    logic [31:0] cfg; logic wr; logic [10:0] addr; logic [5:0] data;
    logic busy; logic err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t rec(logic v, logic [7:0] d, logic vb, logic a,
                               logic [31:0] cfg, logic wr, logic [10:0] addr,
                               logic [5:0] data, logic b, logic e);
    vec_t r;
    r.v = v; r.d = d; r.vb = vb; r.a = a; r.cfg = cfg; r.wr = wr;
    r.addr = addr; r.data = data; r.busy = b; r.err = e;
    return r;
  endfunction

  localparam logic [31:0] C1 = 32'h12345678;
  localparam logic [31:0] C2 = 32'h9ABCDEF0;

  int wr_seen;
  int mode_dense;
  logic [7:0] rb;

  initial begin
    // config load then commit at a later vblank
    tbl.push_back(rec(1, 8'hA0, 0, 1, CFG_RST, 0, 0, 0, 0, 0));
    tbl.push_back(rec(1, 8'h12, 0, 1, CFG_RST, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'h34, 0, 1, CFG_RST, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'h56, 0, 1, CFG_RST, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'h78, 0, 1, CFG_RST, 0, 0, 0, 1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, CFG_RST, 0, 0, 0, 0, 0));
    tbl.push_back(rec(0, 8'h00, 1, 1, CFG_RST, 0, 0, 0, 0, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, C1,      0, 0, 0, 0, 0));
    // last CFG byte coincides with vblank: commit deferred to next pulse
    tbl.push_back(rec(1, 8'hA0, 0, 1, C1, 0, 0, 0, 0, 0));
    tbl.push_back(rec(1, 8'h9A, 0, 1, C1, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'hBC, 0, 1, C1, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'hDE, 0, 1, C1, 0, 0, 0, 1, 0));
    tbl.push_back(rec(1, 8'hF0, 1, 1, C1, 0, 0, 0, 1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, C1, 0, 0, 0, 0, 0));
    tbl.push_back(rec(0, 8'h00, 1, 1, C1, 0, 0, 0, 0, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, C2, 0, 0, 0, 0, 0));
    // char write held off by active, lands when active drops
    tbl.push_back(rec(1, 8'hB0, 0, 1, C2, 0, 0,   0,     0, 0));
    tbl.push_back(rec(1, 8'h01, 0, 1, C2, 0, 0,   0,     1, 0));
    tbl.push_back(rec(1, 8'h2C, 0, 1, C2, 0, 0,   0,     1, 0));
    tbl.push_back(rec(1, 8'h3F, 0, 1, C2, 0, 0,   0,     1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, C2, 0, 0,   0,     1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 1, C2, 0, 0,   0,     1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 0, C2, 1, 300, 6'h3F, 1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 0, C2, 0, 300, 6'h3F, 0, 0));
    // address 1200 is out of range: error, no write; E0 clears
    tbl.push_back(rec(1, 8'hB0, 0, 0, C2, 0, 300, 6'h3F, 0, 0));
    tbl.push_back(rec(1, 8'h04, 0, 0, C2, 0, 300, 6'h3F, 1, 0));
    tbl.push_back(rec(1, 8'hB0, 0, 0, C2, 0, 300, 6'h3F, 1, 0));
    tbl.push_back(rec(1, 8'h01, 0, 0, C2, 0, 300, 6'h3F, 1, 0));
    tbl.push_back(rec(0, 8'h00, 0, 0, C2, 0, 300, 6'h3F, 0, 1));
    tbl.push_back(rec(1, 8'hE0, 0, 0, C2, 0, 300, 6'h3F, 0, 1));
    tbl.push_back(rec(0, 8'h00, 0, 0, C2, 0, 300, 6'h3F, 0, 0));

    // reset state
    rst_n = 0;
    drive(0, 8'h00, 0, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset config_out", config_out, CFG_RST);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset char_wr", 32'(char_wr), 32'd0);
    rst_n = 1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].vb, tbl[i].a);
      sample();
      n_vec++;
      if ({config_out, char_wr, char_addr, char_data, busy, err} !==
          {tbl[i].cfg, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].err}) begin
        n_bad++;
        $display("FAIL table row %0d: got cfg=%h wr=%b addr=%0d data=%h busy=%b err=%b, want cfg=%h wr=%b addr=%0d data=%h busy=%b err=%b",
                 i, config_out, char_wr, char_addr, char_data, busy, err,
                 tbl[i].cfg, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].err);
      end
      advance();
    end

    // timeout: stage 11223344 uncommitted, then abandon A0,AA
    step(1, 8'hA0, 0, 0); step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    step(1, 8'hA0, 0, 0); step(1, 8'hAA, 0, 0);
    repeat (TMO - 1) step(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0); sample();
    chk("timeout-1 busy", 32'(busy), 32'd1);
    chk("timeout-1 err", 32'(err), 32'd0);
    advance();
    drive(0, 8'h00, 0, 0); sample();
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout busy", 32'(busy), 32'd0);
    advance();
    step(1, 8'hC0, 0, 0);
    drive(0, 8'h00, 0, 0); sample();
    chk("commit after timeout", config_out, 32'h11223344);
    advance();
    step(1, 8'hE0, 0, 0);

    // reset in the middle of a char command
    step(1, 8'hB0, 0, 0); step(1, 8'h00, 0, 0); step(1, 8'h05, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset config_out", config_out, CFG_RST);
    model_reset();
    drive(0, 8'h00, 0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    wr_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 8'h00, (i % 3) == 1, 0);
      sample();
      if (char_wr) wr_seen++;
      advance();
    end
    chk("no write after reset", 32'(wr_seen), 32'd0);
    drive(0, 8'h00, 0, 0); sample();
    chk("postreset config_out", config_out, CFG_RST);
    advance();

    // random traffic against the model
    mode_dense = 1;
    active = 1;
    for (int c = 0; c < 4000; c++) begin
      logic v, vb, a;
      if (c % 200 == 0) mode_dense = $urandom_range(0, 1);
      v  = mode_dense ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 19) == 0);
      vb = ($urandom_range(0, 24) == 0);
      a  = ($urandom_range(0, 15) == 0) ? !active : active;
      case ($urandom_range(0, 9))
        0: rb = 8'hA0;
        1: rb = 8'hB0;
        2: rb = 8'hC0;
        3: rb = 8'hE0;
        4: rb = 8'($urandom_range(0, 7));
        5: rb = 8'($urandom_range(8'hAC, 8'hB2));
        default: rb = 8'($urandom);
      endcase
      step(v, rb, vb, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_cmd_sequencer.md
VGA_CMD_SEQUENCER -- requirements
Module: vga_cmd_sequencer

Interface
REQ-001 SHALL have parameter CFG_RESET, default 32'h80FC0000, the configuration value loaded at reset.
REQ-002 SHALL have parameter TIMEOUT, default 1024, the maximum number of clk cycles allowed between bytes of one command.
REQ-003 SHALL have parameter CHAR_CELLS, default 1200, the number of character cells (40x30).
REQ-004 clk  input  1  system/pixel clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 rx_data  input  8  byte received from the SPI peripheral.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-008 vblank_start  input  1  one-cycle pulse at the first line of vertical blanking.
REQ-009 active  input  1  high while the timing generator is in visible area.
REQ-010 config_out  output  32  live configuration register driving the pixel mux.
REQ-011 char_wr  output  1  one-cycle write strobe to the character row memory.
REQ-012 char_addr  output  11  character cell index for char_wr.
REQ-013 char_data  output  6  character code for char_wr.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL implement FSM states IDLE, CFG_BYTES, CHAR_BYTES, WAIT_BLANK.
REQ-017 In IDLE, a byte is an opcode: 0xA0 -> CFG_BYTES; 0xB0 -> CHAR_BYTES; 0xC0 -> copy shadow to config_out next cycle, clear commit_pending; 0xE0 -> clear err; any other -> set err, stay IDLE.
REQ-018 CFG_BYTES SHALL accept 4 bytes MSB-first into a 32-bit shadow register; after the 4th byte: set commit_pending, go to IDLE.
REQ-019 config_out SHALL load shadow on a vblank_start cycle only if commit_pending was already set before that cycle; commit_pending then clears.
REQ-020 If the final CFG byte and vblank_start coincide, commit SHALL occur at the next vblank_start, not the current one.
REQ-021 CHAR_BYTES SHALL accept 3 bytes: addr[10:8] in byte0[2:0], addr[7:0] in byte1, code in byte2[5:0]; unused bits ignored.
REQ-022 After byte2: if addr >= CHAR_CELLS -> set err, go to IDLE with no write; else go to WAIT_BLANK.
REQ-023 In WAIT_BLANK, char_wr SHALL pulse for exactly one cycle in the first cycle with active==0, with char_addr/char_data valid in that cycle; the FSM then returns to IDLE.
REQ-024 A write requested while active==0 SHALL issue char_wr on the cycle after byte2 (latency 1).
REQ-025 rx_valid in WAIT_BLANK SHALL set err and discard the byte.
REQ-026 In CFG_BYTES/CHAR_BYTES, an inter-byte counter SHALL reload on every rx_valid; reaching TIMEOUT cycles without rx_valid SHALL set err, discard the partial command and go to IDLE; shadow keeps its prior complete value.
REQ-027 char_addr/char_data SHALL hold their last written values when char_wr is low.
REQ-028 err SHALL be cleared only by reset or opcode 0xE0; if 0xE0 coincides with a new error, the clear takes priority.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, config_out=CFG_RESET, shadow=CFG_RESET, commit_pending=0, char_wr=0, char_addr=0, char_data=0, busy=0, err=0, counters=0.
REQ-030 Reset mid-command SHALL drop the command; no char_wr or commit SHALL follow deassertion.

Verification
REQ-031 Reset -> config_out=32'h80FC0000, busy=0, err=0, char_wr=0.
REQ-032 Send A0,12,34,56,78 then vblank_start -> config_out unchanged until the pulse, 32'h12345678 the next cycle; repeat with final byte coinciding with vblank_start -> commit at next pulse only.
REQ-033 active=1, send B0,01,2C,3F -> FSM in WAIT_BLANK, no char_wr; drop active -> one char_wr with char_addr=300, char_data=6'h3F.
REQ-034 Send B0,04,B0,01 (addr 1200) -> err=1, no char_wr; then E0 -> err=0.
REQ-035 Send A0,AA then idle TIMEOUT cycles -> err=1, busy=0, shadow unchanged; send C0 -> config_out=previous shadow.
REQ-036 Assert rst_n low during CHAR_BYTES after byte1 -> immediate IDLE, no char_wr after release.
